// File: rtl/control_unit_if.sv
// Control bus between the instruction register / datapath and the control unit.
// The master side is the controller: it reads the latched instruction and drives every control line.
interface control_unit_if #(
    parameter int ADDR_W = 8,
    parameter int REG_W  = 4
);
    logic [15:0]       instruction;
    logic              pc_clr;
    logic              pc_up;
    logic              ir_clr;
    logic              ir_ld;
    logic [ADDR_W-1:0] d_addr;
    logic              d_wr;
    logic              rf_s;
    logic [REG_W-1:0]  rf_w_addr;
    logic              rf_w_wr;
    logic [REG_W-1:0]  rf_ra_addr;
    logic [REG_W-1:0]  rf_rb_addr;
    logic [2:0]        alu_s;
    logic              halted;
    logic [3:0]        state;

    modport master (
        input  instruction,
        output pc_clr, pc_up, ir_clr, ir_ld,
        output d_addr, d_wr,
        output rf_s, rf_w_addr, rf_w_wr, rf_ra_addr, rf_rb_addr,
        output alu_s, halted, state
    );

    modport slave (
        output instruction,
        input  pc_clr, pc_up, ir_clr, ir_ld,
        input  d_addr, d_wr,
        input  rf_s, rf_w_addr, rf_w_wr, rf_ra_addr, rf_rb_addr,
        input  alu_s, halted, state
    );
endinterface

// File: rtl/control_unit.sv
// Moore fetch/decode/execute controller for the six-opcode processor.
// Outputs depend only on the state register and the (stable) latched instruction fields.
module control_unit #(
    parameter int OP_W   = 4,
    parameter int ADDR_W = 8,
    parameter int REG_W  = 4
) (
    input  logic          clock,
    input  logic          reset,
    control_unit_if.master cu
);
    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_e;

    localparam logic [OP_W-1:0] OPC_NOOP  = OP_W'(0);
    localparam logic [OP_W-1:0] OPC_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OPC_LOAD  = OP_W'(2);
    localparam logic [OP_W-1:0] OPC_ADD   = OP_W'(3);
    localparam logic [OP_W-1:0] OPC_SUB   = OP_W'(4);
    localparam logic [OP_W-1:0] OPC_HALT  = OP_W'(5);

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;

    state_e state_q;
    state_e state_d;

    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  ra;
    logic [REG_W-1:0]  rb;
    logic [REG_W-1:0]  rc;
    logic [ADDR_W-1:0] d;

    assign op = cu.instruction[15 -: OP_W];
    assign ra = cu.instruction[11 -: REG_W];
    assign rb = cu.instruction[7 -: REG_W];
    assign rc = cu.instruction[REG_W-1:0];
    assign d  = cu.instruction[ADDR_W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; unused encodings fall back to INIT so an upset self-recovers.
    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OPC_NOOP:  state_d = S_NOOP;
                    OPC_STORE: state_d = S_STORE;
                    OPC_LOAD:  state_d = S_LOAD_A;
                    OPC_ADD:   state_d = S_ADD;
                    OPC_SUB:   state_d = S_SUB;
                    OPC_HALT:  state_d = S_HALT;
                    default:   state_d = S_NOOP;
                endcase
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_FETCH;
            S_STORE:  state_d = S_FETCH;
            S_ADD:    state_d = S_FETCH;
            S_SUB:    state_d = S_FETCH;
            S_NOOP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    always_comb begin
        cu.pc_clr     = 1'b0;
        cu.pc_up      = 1'b0;
        cu.ir_clr     = 1'b0;
        cu.ir_ld      = 1'b0;
        cu.d_addr     = '0;
        cu.d_wr       = 1'b0;
        cu.rf_s       = 1'b0;
        cu.rf_w_addr  = '0;
        cu.rf_w_wr    = 1'b0;
        cu.rf_ra_addr = '0;
        cu.rf_rb_addr = '0;
        cu.alu_s      = ALU_PASS_A;
        cu.halted     = 1'b0;
        case (state_q)
            S_INIT: begin
                cu.pc_clr = 1'b1;
                cu.ir_clr = 1'b1;
            end
            S_FETCH: begin
                cu.ir_ld = 1'b1;
                cu.pc_up = 1'b1;
            end
            // LOAD_A only presents the address so the synchronous memory read completes before the write.
            S_LOAD_A, S_LOAD_B: begin
                cu.d_addr    = d;
                cu.rf_s      = 1'b1;
                cu.rf_w_addr = ra;
                cu.rf_w_wr   = (state_q == S_LOAD_B);
            end
            S_STORE: begin
                cu.d_addr     = d;
                cu.rf_ra_addr = ra;
                cu.alu_s      = ALU_PASS_A;
                cu.d_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                cu.rf_ra_addr = rb;
                cu.rf_rb_addr = rc;
                cu.alu_s      = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
                cu.rf_w_addr  = ra;
                cu.rf_w_wr    = 1'b1;
            end
            S_HALT: cu.halted = 1'b1;
            default: ;
        endcase
    end

    assign cu.state = state_q;
endmodule

// File: tb/tb_control_unit.sv
// Directed scoreboard bench for control_unit: expected output vectors are queued as each instruction is
// driven and popped one per clock, sampled 2 time units after the rising edge.
module tb_control_unit;
    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    control_unit_if #(.ADDR_W(8), .REG_W(4)) cu ();

    control_unit #(.OP_W(4), .ADDR_W(8), .REG_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .cu    (cu)
    );

    typedef struct packed {
        logic [3:0] state;
        logic       pc_clr;
        logic       pc_up;
        logic       ir_clr;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] rf_w_addr;
        logic       rf_w_wr;
        logic [3:0] rf_ra_addr;
        logic [3:0] rf_rb_addr;
        logic [2:0] alu_s;
        logic       halted;
    } out_t;

    typedef struct {
        string tag;
        out_t  v;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic out_t base(input logic [3:0] st);
        out_t o;
        o = '0;
        o.state = st;
        return o;
    endfunction

    function automatic out_t ex_init();
        out_t o;
        o = base(4'd0);
        o.pc_clr = 1'b1;
        o.ir_clr = 1'b1;
        return o;
    endfunction

    function automatic out_t ex_fetch();
        out_t o;
        o = base(4'd1);
        o.ir_ld = 1'b1;
        o.pc_up = 1'b1;
        return o;
    endfunction

    function automatic out_t ex_load(input logic second, input logic [7:0] a, input logic [3:0] w);
        out_t o;
        o = base(second ? 4'd5 : 4'd4);
        o.d_addr    = a;
        o.rf_s      = 1'b1;
        o.rf_w_addr = w;
        o.rf_w_wr   = second;
        return o;
    endfunction

    function automatic out_t ex_store(input logic [7:0] a, input logic [3:0] r);
        out_t o;
        o = base(4'd6);
        o.d_addr     = a;
        o.rf_ra_addr = r;
        o.alu_s      = 3'b000;
        o.d_wr       = 1'b1;
        return o;
    endfunction

    function automatic out_t ex_alu(input logic [3:0] st, input logic [2:0] sel, input logic [3:0] w,
                                    input logic [3:0] a, input logic [3:0] b);
        out_t o;
        o = base(st);
        o.rf_ra_addr = a;
        o.rf_rb_addr = b;
        o.alu_s      = sel;
        o.rf_w_addr  = w;
        o.rf_w_wr    = 1'b1;
        return o;
    endfunction

    function automatic out_t ex_halt();
        out_t o;
        o = base(4'd9);
        o.halted = 1'b1;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.state      = cu.state;
        o.pc_clr     = cu.pc_clr;
        o.pc_up      = cu.pc_up;
        o.ir_clr     = cu.ir_clr;
        o.ir_ld      = cu.ir_ld;
        o.d_addr     = cu.d_addr;
        o.d_wr       = cu.d_wr;
        o.rf_s       = cu.rf_s;
        o.rf_w_addr  = cu.rf_w_addr;
        o.rf_w_wr    = cu.rf_w_wr;
        o.rf_ra_addr = cu.rf_ra_addr;
        o.rf_rb_addr = cu.rf_rb_addr;
        o.alu_s      = cu.alu_s;
        o.halted     = cu.halted;
        return o;
    endfunction

    task automatic push(input string tag, input out_t v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        out_t obs;
        obs = sample();
        vectors++;
        assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL sb_empty: observed %h with no expected vector queued", obs);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            assert (obs === e.v) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h (state %0d vs %0d)",
                       e.tag, obs, e.v, obs.state, e.v.state);
            end
            $display("t=%0t %s state=%0d obs=%h exp=%h", $time, e.tag, obs.state, obs, e.v);
        end
        vectors++;
        assert (!((obs.d_wr === 1'b1) && (obs.rf_w_wr === 1'b1))) else begin
            miscompares++;
            $error("FAIL single_write: observed d_wr=%b rf_w_wr=%b expected at most one high",
                   obs.d_wr, obs.rf_w_wr);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
            compare_head();
        end
    endtask

    initial begin
        cu.instruction = 16'h0000;

        // Asynchronous reset asserted mid-cycle and held for two edges.
        #12;
        reset = 1'b1;
        push("rst_async", ex_init());
        #1 compare_head();
        push("rst_hold0", ex_init());
        push("rst_hold1", ex_init());
        run(2);
        @(negedge clock);
        reset = 1'b0;

        push("boot_fetch", ex_fetch());
        push("boot_decode", base(4'd2));
        push("boot_noop", base(4'd3));
        run(3);

        push("load_fetch", ex_fetch());
        run(1);
        cu.instruction = 16'h2A1B;
        push("load_decode", base(4'd2));
        push("load_a", ex_load(1'b0, 8'h1B, 4'hA));
        push("load_b", ex_load(1'b1, 8'h1B, 4'hA));
        run(3);

        push("store_fetch", ex_fetch());
        run(1);
        cu.instruction = 16'h1305;
        push("store_decode", base(4'd2));
        push("store_exec", ex_store(8'h05, 4'h3));
        run(2);

        push("add_fetch", ex_fetch());
        run(1);
        cu.instruction = 16'h3412;
        push("add_decode", base(4'd2));
        push("add_exec", ex_alu(4'd7, 3'b001, 4'h4, 4'h1, 4'h2));
        run(2);

        push("sub_fetch", ex_fetch());
        run(1);
        cu.instruction = 16'h4412;
        push("sub_decode", base(4'd2));
        push("sub_exec", ex_alu(4'd8, 3'b010, 4'h4, 4'h1, 4'h2));
        run(2);

        push("undef_fetch", ex_fetch());
        run(1);
        cu.instruction = 16'hF123;
        push("undef_decode", base(4'd2));
        push("undef_noop", base(4'd3));
        push("undef_refetch", ex_fetch());
        run(3);

        // Reset lands in the middle of LOAD_A; the LOAD_B write must never appear.
        cu.instruction = 16'h2A1B;
        push("midload_decode", base(4'd2));
        push("midload_a", ex_load(1'b0, 8'h1B, 4'hA));
        run(2);
        #3;
        reset = 1'b1;
        cu.instruction = 16'h0000;
        push("midload_rst", ex_init());
        #1 compare_head();
        push("midload_rst_hold", ex_init());
        run(1);
        @(negedge clock);
        reset = 1'b0;
        push("restart_fetch", ex_fetch());
        push("restart_decode", base(4'd2));
        push("restart_noop", base(4'd3));
        run(3);

        push("halt_fetch", ex_fetch());
        run(1);
        cu.instruction = 16'h5000;
        push("halt_decode", base(4'd2));
        for (int i = 0; i < 22; i++) begin
            push("halt_hold", ex_halt());
        end
        run(23);

        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL sb_drain: observed %0d leftover expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Moore FSM controller sitting directly downstream of the instruction register. It consumes the latched 16-bit instruction and drives every datapath control line.
- Controlled blocks: PC (clear/increment), instruction register (clear/load), data memory (address/write), register file (read/write addresses, write enable, write-source mux) and ALU (operation select).
- Sequences fetch, decode and execute for the six-opcode processor.

Parameters:
- OP_W, 4, opcode width (instruction[15:12]).
- ADDR_W, 8, data-memory address width (instruction[7:0]).
- REG_W, 4, register-file address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instruction  in  16  current instruction from the instruction register.
- pc_clr  out  1  synchronous clear of the PC.
- pc_up  out  1  PC increment enable.
- ir_clr  out  1  clear input of the instruction register.
- ir_ld  out  1  load input of the instruction register.
- d_addr  out  8  data-memory address.
- d_wr  out  1  data-memory write enable.
- rf_s  out  1  register-file write source: 1 = data memory, 0 = ALU.
- rf_w_addr  out  4  register-file write address.
- rf_w_wr  out  1  register-file write enable.
- rf_ra_addr  out  4  read port A address.
- rf_rb_addr  out  4  read port B address.
- alu_s  out  3  ALU select: 000 = pass A, 001 = A+B, 010 = A-B.
- halted  out  1  high while in HALT.
- state  out  4  current state encoding, for debug/display.

Behaviour:
- Instruction fields:
  - op = [15:12].
  - LOAD 0010 and STORE 0001: Ra = [11:8], d = [7:0].
  - ADD 0011 and SUB 0100: Ra = [11:8] (destination), Rb = [7:4], Rc = [3:0].
  - NOOP 0000, HALT 0101.
  - Opcodes 0110–1111 are treated as NOOP.
- State encoding: INIT = 0, FETCH = 1, DECODE = 2, NOOP = 3, LOAD_A = 4, LOAD_B = 5, STORE = 6, ADD = 7, SUB = 8, HALT = 9. Codes 10–15 are illegal and go to INIT on the next edge.
- Reset: asynchronous, forces state = INIT immediately, mid-instruction included. No memory or register write may be issued in the reset cycle.
- Transitions:
  - INIT → FETCH.
  - FETCH → DECODE.
  - DECODE → {NOOP, LOAD_A, STORE, ADD, SUB, HALT} by op.
  - LOAD_A → LOAD_B.
  - LOAD_B, STORE, ADD, SUB, NOOP → FETCH.
  - HALT → HALT; only reset exits.
- Outputs are Moore: decoded from the state register plus the instruction fields. Any output not listed for a state is 0, and all address outputs default to 0.
  - INIT: pc_clr = 1, ir_clr = 1.
  - FETCH: ir_ld = 1, pc_up = 1. The ROM output for the current PC is valid during FETCH; the IR captures it at the end of FETCH, and the PC increments on the same edge.
  - DECODE: no side effects; instruction is stable.
  - LOAD_A: d_addr = d, rf_s = 1, rf_w_addr = Ra. This allows the 1-cycle synchronous memory read.
  - LOAD_B: same as LOAD_A, plus rf_w_wr = 1.
  - STORE: d_addr = d, rf_ra_addr = Ra, alu_s = 000, d_wr = 1. Memory data comes from RF port A.
  - ADD: rf_ra_addr = Rb, rf_rb_addr = Rc, alu_s = 001, rf_s = 0, rf_w_addr = Ra, rf_w_wr = 1.
  - SUB: same as ADD with alu_s = 010.
  - HALT: halted = 1. pc_up and ir_ld stay 0, so the PC is frozen.
- Latency in cycles, FETCH to next FETCH: NOOP 3, STORE 3, ADD 3, SUB 3, LOAD 4.
- Single-write rule: at most one of d_wr and rf_w_wr is high in any cycle.
- The instruction must not change outside the FETCH→DECODE edge; the controller relies on this.

Test Plan:
- Reset/boot: assert reset mid-cycle for 2 cycles → state = 0, pc_clr = 1, ir_clr = 1 asynchronously. After release: FETCH with ir_ld = 1, pc_up = 1; then DECODE.
- LOAD: instruction = 16'h2A1B → DECODE, LOAD_A, LOAD_B. In both states d_addr = 8'h1B, rf_w_addr = 4'hA, rf_s = 1. rf_w_wr = 1 only in LOAD_B. Returns to FETCH.
- STORE: instruction = 16'h1305 → STORE state with d_addr = 8'h05, rf_ra_addr = 3, d_wr = 1 for exactly 1 cycle, rf_w_wr = 0.
- ADD/SUB: 16'h3412 → rf_ra_addr = 1, rf_rb_addr = 2, alu_s = 001, rf_w_addr = 4, rf_w_wr = 1, rf_s = 0. 16'h4412 → identical except alu_s = 010.
- HALT/undefined: 16'h5000 → halted = 1 for 20+ cycles with no pc_up. 16'hF123 → behaves as NOOP; FETCH follows 3 cycles after the prior FETCH.
- Reset mid-LOAD: assert reset during LOAD_A → rf_w_wr never goes high. Restart is clean through INIT.
